median_frame_ctrl: RTL

Frame sequencer for the 3-row RGB median filter datapath. It accepts image rows over a valid/ready handshake and drives the shift-load of the three line buffers. It also selects the window mode for top, middle and bottom edge handling, launches each median computation, and presents each filtered row over an output handshake. It replaces free-running row stepping with explicit flow control and edge sequencing over the whole frame.

---
 rtl/median_frame_ctrl_if.sv | 31 +++
 rtl/median_frame_ctrl.sv | 107 ++++++++++
 2 files changed

// File: rtl/median_frame_ctrl_if.sv
// Handshake and control bundle between the frame sequencer and
// the row source, median datapath and row sink.
interface median_frame_ctrl_if #(
  parameter int ROW_W = 9
);
  logic             start;
  logic             abort;
  logic             in_valid;
  logic             in_ready;
  logic             load_en;
  logic [1:0]       win_mode;
  logic             med_go;
  logic             med_done;
  logic             out_valid;
  logic             out_ready;
  logic [ROW_W-1:0] row_idx;
  logic             busy;
  logic             frame_done;

  modport master (
    output start, abort, in_valid, med_done, out_ready,
    input  in_ready, load_en, win_mode, med_go, out_valid,
    input  row_idx, busy, frame_done
  );

  modport slave (
    input  start, abort, in_valid, med_done, out_ready,
    output in_ready, load_en, win_mode, med_go, out_valid,
    output row_idx, busy, frame_done
  );
endinterface

// File: rtl/median_frame_ctrl.sv
// Frame sequencer for the 3-row median filter: line-buffer loads,
// edge window selection, median launch and output row handshake.
module median_frame_ctrl #(
  parameter int ROWS  = 256,
  parameter int ROW_W = 9
) (
  input logic CLK,
  input logic RST,
  median_frame_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, FILL, CALC, OUT, LOAD, DONE
  } state_t;

  localparam logic [1:0] W_TOP = 2'b00;
  localparam logic [1:0] W_MID = 2'b01;
  localparam logic [1:0] W_BOT = 2'b10;

  localparam logic [ROW_W-1:0] LAST = ROW_W'(ROWS - 1);
  localparam logic [ROW_W-1:0] ONE  = ROW_W'(1);

  state_t           state;
  logic             fill_cnt;
  logic             go_q;
  logic [1:0]       mode_q;
  logic [ROW_W-1:0] row_q;
  logic [ROW_W-1:0] row_nx;

  assign row_nx = row_q + ONE;

  assign bus.in_ready   = (state == FILL) || (state == LOAD);
  assign bus.load_en    = bus.in_valid & bus.in_ready & ~bus.abort;
  assign bus.out_valid  = (state == OUT);
  assign bus.busy       = (state != IDLE);
  assign bus.frame_done = (state == DONE);
  assign bus.win_mode   = mode_q;
  assign bus.row_idx    = row_q;
  // launch is suppressed in the cycle an abort lands
  assign bus.med_go     = go_q & ~bus.abort;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      fill_cnt <= 1'b0;
      go_q     <= 1'b0;
      mode_q   <= W_TOP;
      row_q    <= '0;
    end else begin
      go_q <= 1'b0;
      if (bus.abort) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.start) begin
              state    <= FILL;
              row_q    <= '0;
              fill_cnt <= 1'b0;
            end
          end
          FILL: begin
            if (bus.in_valid) begin
              if (fill_cnt) begin
                state  <= CALC;
                mode_q <= W_TOP;
                row_q  <= '0;
                go_q   <= 1'b1;
              end else begin
                fill_cnt <= 1'b1;
              end
            end
          end
          CALC: begin
            if (bus.med_done) state <= OUT;
          end
          OUT: begin
            if (bus.out_ready) begin
              if (row_q == LAST) begin
                state <= DONE;
              end else if (row_nx < LAST) begin
                row_q <= row_nx;
                state <= LOAD;
              end else begin
                // last row reuses the buffers: no new input
                row_q  <= row_nx;
                state  <= CALC;
                mode_q <= W_BOT;
                go_q   <= 1'b1;
              end
            end
          end
          LOAD: begin
            if (bus.in_valid) begin
              state  <= CALC;
              mode_q <= W_MID;
              go_q   <= 1'b1;
            end
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
